// File: rtl/bus_transfer_ctrl_if.sv
// Register-bus signal bundle for bus_transfer_ctrl: request inputs, shared read bus,
// register enables/write data and transfer status.
interface bus_transfer_ctrl_if #(
  parameter int unsigned width    = 16,
  parameter int unsigned num_regs = 8,
  parameter int unsigned sel_w    = 3
);
  logic                start;
  logic                op;
  logic [sel_w-1:0]    src;
  logic [sel_w-1:0]    dst;
  logic [width-1:0]    bus_in;
  logic [num_regs-1:0] oe;
  logic [num_regs-1:0] we;
  logic [width-1:0]    wdata;
  logic                busy;
  logic                done;
  logic [7:0]          xfer_cnt;

  modport master (
    input  start, op, src, dst, bus_in,
    output oe, we, wdata, busy, done, xfer_cnt
  );

  modport slave (
    output start, op, src, dst, bus_in,
    input  oe, we, wdata, busy, done, xfer_cnt
  );
endinterface

// File: rtl/bus_transfer_ctrl.sv
// Register-to-register transfer controller: move (or swap) between attached registers.
// Define BUS_TRANSFER_SWAP_EN to enable swap (op=1); otherwise every transfer is a move.
module bus_transfer_ctrl #(
  parameter int unsigned width    = 16,
  parameter int unsigned num_regs = 8,
  parameter int unsigned sel_w    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  bus_transfer_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    WR_A = 3'd2,
    DONE = 3'd3
`ifdef BUS_TRANSFER_SWAP_EN
    ,
    RD_B = 3'd4,
    WR_B = 3'd5
`endif
  } state_t;

  state_t              state;
  logic [sel_w-1:0]    dst_q;
  logic [width-1:0]    tmp_a;
  logic [num_regs-1:0] oe_q;
  logic [num_regs-1:0] we_q;
  logic                busy_q;
  logic                done_q;
  logic [7:0]          cnt_q;
`ifdef BUS_TRANSFER_SWAP_EN
  logic                op_q;
  logic [sel_w-1:0]    src_q;
  logic [width-1:0]    tmp_b;
  logic [width-1:0]    wdata_q;
`endif

  function automatic logic [num_regs-1:0] onehot(input logic [sel_w-1:0] idx);
    logic [num_regs-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      dst_q  <= '0;
      tmp_a  <= '0;
      oe_q   <= '0;
      we_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
`ifdef BUS_TRANSFER_SWAP_EN
      op_q    <= 1'b0;
      src_q   <= '0;
      tmp_b   <= '0;
      wdata_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            dst_q  <= bus.dst;
            oe_q   <= onehot(bus.src);
            busy_q <= 1'b1;
            state  <= RD_A;
`ifdef BUS_TRANSFER_SWAP_EN
            op_q  <= bus.op;
            src_q <= bus.src;
`endif
          end
        end
        RD_A: begin
          tmp_a <= bus.bus_in;
`ifdef BUS_TRANSFER_SWAP_EN
          if (op_q) begin
            oe_q  <= onehot(dst_q);
            state <= RD_B;
          end else begin
            oe_q    <= '0;
            we_q    <= onehot(dst_q);
            wdata_q <= bus.bus_in;
            state   <= WR_A;
          end
`else
          oe_q  <= '0;
          we_q  <= onehot(dst_q);
          state <= WR_A;
`endif
        end
`ifdef BUS_TRANSFER_SWAP_EN
        RD_B: begin
          tmp_b   <= bus.bus_in;
          oe_q    <= '0;
          we_q    <= onehot(dst_q);
          wdata_q <= tmp_a;
          state   <= WR_A;
        end
        WR_A: begin
          if (op_q) begin
            we_q    <= onehot(src_q);
            wdata_q <= tmp_b;
            state   <= WR_B;
          end else begin
            we_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            cnt_q  <= cnt_q + 8'd1;
            state  <= DONE;
          end
        end
        WR_B: begin
          we_q   <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          cnt_q  <= cnt_q + 8'd1;
          state  <= DONE;
        end
`else
        WR_A: begin
          we_q   <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          cnt_q  <= cnt_q + 8'd1;
          state  <= DONE;
        end
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.oe       = oe_q;
  assign bus.we       = we_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.xfer_cnt = cnt_q;
`ifdef BUS_TRANSFER_SWAP_EN
  assign bus.wdata    = wdata_q;
`else
  // Move-only: tmp_a changes only at the RD_A edge, so it doubles as the held write data.
  assign bus.wdata    = tmp_a;
`endif

endmodule
